// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and
// fixed widths used by the fetch datapath.
package if_fetch_stage_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // FETCH: request outstanding; HOLD: skid full, no request;
    // SQUASH: request outstanding but its response is discarded.
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SQUASH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_adder_32.sv
// Combinational adder used for PC+4 and for the branch target; wraps
// silently at 2^WIDTH.
module adder_32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory, fills the IF/ID register and absorbs one instruction
// in a skid buffer when ID stalls. Redirects from ID flush IF/ID and, if a
// fetch is still outstanding, let it complete and drop its data.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_base_i,
    input  logic [ADDR_W-1:0] branch_offset_sl2_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_data_i,
    output logic              ifid_valid_o,
    output logic [31:0]       ifid_instr_o,
    output logic [ADDR_W-1:0] ifid_pc4_o
);

    localparam logic [ADDR_W-1:0] FOUR       = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_e       state, state_next;
    logic [ADDR_W-1:0]  pc, pc_next;
    // Redirect target parked while a squashed fetch drains.
    logic [ADDR_W-1:0]  squash_target, squash_target_next;
    logic [INSTR_W-1:0] skid_instr, skid_instr_next;
    logic [ADDR_W-1:0]  skid_pc4, skid_pc4_next;
    logic               ifid_valid, ifid_valid_next;
    logic [INSTR_W-1:0] ifid_instr, ifid_instr_next;
    logic [ADDR_W-1:0]  ifid_pc4, ifid_pc4_next;

    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  branch_sum;
    logic [ADDR_W-1:0]  redirect_target;
    logic               redirect;
    logic               ack_ok;

    adder_32 #(.WIDTH(ADDR_W)) u_pc_inc (
        .a   (pc),
        .b   (FOUR),
        .sum (pc_plus4)
    );

    adder_32 #(.WIDTH(ADDR_W)) u_branch_add (
        .a   (branch_base_i),
        .b   (branch_offset_sl2_i),
        .sum (branch_sum)
    );

    // Jump wins over branch; targets are always word aligned.
    assign redirect        = jump_i | branch_i;
    assign redirect_target = (jump_i ? jump_target_i : branch_sum) & ALIGN_MASK;

    // Request is withdrawn immediately while reset is asserted.
    assign imem_req_o   = (state != ST_HOLD) && !rst_i;
    assign imem_addr_o  = pc;
    assign ack_ok       = imem_ack_i && imem_req_o;

    assign ifid_valid_o = ifid_valid;
    assign ifid_instr_o = ifid_instr;
    assign ifid_pc4_o   = ifid_pc4;

    // State, PC, skid and IF/ID registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_FETCH;
            pc            <= RESET_PC;
            squash_target <= RESET_PC;
            skid_instr    <= '0;
            skid_pc4      <= '0;
            ifid_valid    <= 1'b0;
            ifid_instr    <= '0;
            ifid_pc4      <= '0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            squash_target <= squash_target_next;
            skid_instr    <= skid_instr_next;
            skid_pc4      <= skid_pc4_next;
            ifid_valid    <= ifid_valid_next;
            ifid_instr    <= ifid_instr_next;
            ifid_pc4      <= ifid_pc4_next;
        end
    end

    // Next-state logic: redirects take priority over stalls in every state.
    always_comb begin
        state_next         = state;
        pc_next            = pc;
        squash_target_next = squash_target;
        skid_instr_next    = skid_instr;
        skid_pc4_next      = skid_pc4;
        ifid_valid_next    = ifid_valid;
        ifid_instr_next    = ifid_instr;
        ifid_pc4_next      = ifid_pc4;

        case (state)
            ST_FETCH: begin
                if (redirect) begin
                    ifid_valid_next = 1'b0;
                    if (ack_ok) begin
                        pc_next = redirect_target;
                    end else begin
                        squash_target_next = redirect_target;
                        state_next         = ST_SQUASH;
                    end
                end else if (ack_ok) begin
                    pc_next = pc_plus4;
                    if (stall_i) begin
                        skid_instr_next = imem_data_i;
                        skid_pc4_next   = pc_plus4;
                        state_next      = ST_HOLD;
                    end else begin
                        ifid_valid_next = 1'b1;
                        ifid_instr_next = imem_data_i;
                        ifid_pc4_next   = pc_plus4;
                    end
                end else if (!stall_i) begin
                    ifid_valid_next = 1'b0;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    ifid_valid_next = 1'b0;
                    pc_next         = redirect_target;
                    state_next      = ST_FETCH;
                end else if (!stall_i) begin
                    ifid_valid_next = 1'b1;
                    ifid_instr_next = skid_instr;
                    ifid_pc4_next   = skid_pc4;
                    state_next      = ST_FETCH;
                end
            end

            ST_SQUASH: begin
                // Old request stays on the bus; its data is never used.
                ifid_valid_next = 1'b0;
                if (redirect) begin
                    squash_target_next = redirect_target;
                end
                if (ack_ok) begin
                    pc_next    = redirect ? redirect_target : squash_target;
                    state_next = ST_FETCH;
                end
            end

            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage. The bench plays both instruction
// memory (random wait states, data a fixed function of address) and the ID
// stage (random stalls, branches and jumps). The reference is the program-
// order stream ID must observe: each consumed instruction is followed by
// the one at PC+4, or by the redirect target if ID redirected on it.
module tb_if_fetch_stage;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          N_CYCLES = 2400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic        jump_i = 1'b0;
    logic [31:0] branch_base_i = '0;
    logic [31:0] branch_offset_sl2_i = '0;
    logic [31:0] jump_target_i = '0;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        ifid_valid_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc4_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    if_fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .stall_i             (stall_i),
        .branch_i            (branch_i),
        .branch_base_i       (branch_base_i),
        .branch_offset_sl2_i (branch_offset_sl2_i),
        .jump_i              (jump_i),
        .jump_target_i       (jump_target_i),
        .imem_req_o          (imem_req_o),
        .imem_addr_o         (imem_addr_o),
        .imem_ack_i          (imem_ack_i),
        .imem_data_i         (imem_data_i),
        .ifid_valid_o        (ifid_valid_o),
        .ifid_instr_o        (ifid_instr_o),
        .ifid_pc4_o          (ifid_pc4_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check32("rst_req",   {31'b0, imem_req_o},   32'd0);
        check32("rst_valid", {31'b0, ifid_valid_o}, 32'd0);
        check32("rst_instr", ifid_instr_o,          32'd0);
        check32("rst_pc4",   ifid_pc4_o,            32'd0);
    endtask

    // Instruction memory: random wait states, checks req/addr stability.
    initial begin
        int          wcnt;
        logic        pending;
        logic [31:0] paddr;
        wcnt    = -1;
        pending = 1'b0;
        paddr   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                imem_ack_i = 1'b0;
                wcnt       = -1;
                pending    = 1'b0;
            end else begin
                if (pending) begin
                    check32("hs_req",  {31'b0, imem_req_o}, 32'd1);
                    check32("hs_addr", imem_addr_o, paddr);
                end
                if (!imem_req_o) begin
                    imem_ack_i = 1'b0;
                    wcnt       = -1;
                    pending    = 1'b0;
                end else begin
                    if (wcnt < 0)
                        wcnt = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
                    if (wcnt == 0) begin
                        imem_ack_i  = 1'b1;
                        imem_data_i = mem_word(imem_addr_o);
                        wcnt        = -1;
                        pending     = 1'b0;
                    end else begin
                        imem_ack_i  = 1'b0;
                        imem_data_i = $urandom;
                        wcnt--;
                        pending     = 1'b1;
                        paddr       = imem_addr_o;
                    end
                end
            end
        end
    end

    // Monitor: on every cycle ID consumes IF/ID, compare with the scoreboard.
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && ifid_valid_o && !stall_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_extra got pc4 %h want none", ifid_pc4_o);
                end else begin
                    a = exp_q.pop_front();
                    check32("stream_pc4",   ifid_pc4_o,   a + 32'd4);
                    check32("stream_instr", ifid_instr_o, mem_word(a));
                end
            end
        end
    end

    // ID-stage driver: random stalls and redirects, feeds the scoreboard.
    initial begin
        logic [31:0] cur;
        logic [31:0] tgt;
        logic [31:0] off;
        int          o;
        int          kind;
        int          idle;
        bit          stuck;
        cur   = RESET_PC;
        idle  = 0;
        stuck = 1'b0;
        exp_q.push_back(cur);
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 1; cyc <= N_CYCLES; cyc++) begin
            @(negedge clk);
            if (cyc % 800 == 0) begin
                stall_i  = 1'b1;
                branch_i = 1'b0;
                jump_i   = 1'b0;
                #3;
                rst = 1'b1;
                #1;
                check_reset_outputs();
                @(negedge clk);
                @(negedge clk);
                exp_q.delete();
                cur = RESET_PC;
                exp_q.push_back(cur);
                stall_i = 1'b0;
                rst     = 1'b0;
                idle    = 0;
                continue;
            end
            stall_i             = ($urandom_range(0, 3) == 0);
            branch_i            = 1'b0;
            jump_i              = 1'b0;
            branch_base_i       = $urandom;
            branch_offset_sl2_i = $urandom;
            jump_target_i       = $urandom;
            if (ifid_valid_o && !stall_i) begin
                idle = 0;
                kind = int'($urandom_range(0, 11));
                if (cyc % 300 == 150)
                    kind = 20;
                case (kind)
                    0: begin
                        o                   = int'($urandom_range(0, 511)) - 256;
                        off                 = 32'(o) << 2;
                        branch_i            = 1'b1;
                        branch_base_i       = cur + 32'd4;
                        branch_offset_sl2_i = off;
                        tgt                 = cur + 32'd4 + off;
                    end
                    1: begin
                        jump_i        = 1'b1;
                        jump_target_i = $urandom_range(0, 4095);
                        tgt           = jump_target_i & ~32'd3;
                    end
                    2: begin
                        branch_i      = 1'b1;
                        jump_i        = 1'b1;
                        jump_target_i = $urandom_range(0, 4095);
                        tgt           = jump_target_i & ~32'd3;
                    end
                    20: begin
                        jump_i        = 1'b1;
                        jump_target_i = 32'hFFFF_FFF6;
                        tgt           = 32'hFFFF_FFF4;
                    end
                    default: begin
                        tgt = cur + 32'd4;
                    end
                endcase
                exp_q.push_back(tgt);
                cur = tgt;
            end else begin
                idle++;
                if (idle > 80) begin
                    checks++;
                    errors++;
                    $display("FAIL progress got %0d idle cycles want at most 80", idle);
                    stuck = 1'b1;
                end
            end
            if (stuck)
                break;
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
